// File: rtl/clk_sel_ctrl.sv
// Clock-mux select controller: heartbeat liveness monitors for both sources plus a request/settle FSM.
// Optional feature macro: AUTO_FAILOVER_EN (leave a dead selected source for a live one unrequested).
module clk_sel_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int HB_TIMEOUT    = 64,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic aclk,
  input  logic areset,
  input  logic sel_req,
  input  logic hb_in1,
  input  logic hb_in2,
  output logic selection,
  output logic switching,
  output logic sel_done,
  output logic sel_fault,
  output logic clk1_alive,
  output logic clk2_alive
);

  localparam int HW = $clog2(HB_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [HW-1:0] HB_MAX      = HW'(HB_TIMEOUT);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, CHECK, SWITCH, SETTLE} state_e;

  // Index 0 tracks aclk_in1, index 1 tracks aclk_in2.
  logic [1:0]                  hb_in;
  logic [1:0][SYNC_STAGES-1:0] hb_sync_q, hb_sync_d;
  logic [1:0]                  hb_last_q, hb_last_d;
  logic [1:0][HW-1:0]          hb_cnt_q, hb_cnt_d;
  logic [1:0]                  alive_q, alive_d;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          req_q, req_d;
  logic          fault_q, fault_d;
  logic          switching_q, switching_d;
  logic          done_q, done_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          failover;
  logic          req_allowed;

  assign hb_in = {hb_in2, hb_in1};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hb_sync_d[i] = {hb_sync_q[i][SYNC_STAGES-2:0], hb_in[i]};
      hb_last_d[i] = hb_sync_q[i][SYNC_STAGES-1];
      if (hb_sync_q[i][SYNC_STAGES-1] ^ hb_last_q[i]) begin
        hb_cnt_d[i] = '0;
      end else if (hb_cnt_q[i] != HB_MAX) begin
        hb_cnt_d[i] = hb_cnt_q[i] + HW'(1);
      end else begin
        hb_cnt_d[i] = hb_cnt_q[i];
      end
      alive_d[i] = (hb_cnt_q[i] < HB_MAX);
    end
  end

`ifdef AUTO_FAILOVER_EN
  assign failover = !alive_q[sel_q] && alive_q[!sel_q];
`else
  assign failover = 1'b0;
`endif

  // A refused request stays parked until sel_req moves or its target comes back alive.
  assign req_allowed = !fault_q || (sel_req != req_q) || alive_q[sel_req];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    sel_d    = sel_q;
    req_d    = req_q;
    fault_d  = fault_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (failover) begin
          state_d = SWITCH;
          req_d   = !sel_q;
          fault_d = 1'b1;
        end else if ((sel_req != sel_q) && req_allowed) begin
          state_d = CHECK;
          req_d   = sel_req;
        end else if (sel_req == sel_q) begin
          fault_d = 1'b0;
        end
      end
      CHECK: begin
        if (alive_q[req_q]) begin
          state_d = SWITCH;
          fault_d = 1'b0;
        end else begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      SWITCH: begin
        sel_d    = req_q;
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SW'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    switching_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hb_sync_q   <= '0;
      hb_last_q   <= '0;
      hb_cnt_q    <= {2{HB_MAX}};
      alive_q     <= '0;
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      req_q       <= 1'b0;
      fault_q     <= 1'b0;
      switching_q <= 1'b0;
      done_q      <= 1'b0;
      settle_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values, independent of statement order.
      hb_sync_q   <= hb_sync_d;
      hb_last_q   <= hb_last_d;
      hb_cnt_q    <= hb_cnt_d;
      alive_q     <= alive_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      req_q       <= req_d;
      fault_q     <= fault_d;
      switching_q <= switching_d;
      done_q      <= done_d;
      settle_q    <= settle_d;
    end
  end

  assign selection  = sel_q;
  assign switching  = switching_q;
  assign sel_done   = done_q;
  assign sel_fault  = fault_q;
  assign clk1_alive = alive_q[0];
  assign clk2_alive = alive_q[1];

endmodule
